// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and the iteration-counter width helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } muldiv_state_t;

    // Ceiling log2; callers pass WIDTH+1 so the counter can hold WIDTH itself.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the datapath: shift-add multiply step or
// restoring divide step on the 2*WIDTH accumulator, selected by div_mode_i.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 div_mode_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Remainder shifted left with the next dividend bit pulled in from below.
        partial = acc_i[2*WIDTH-1:WIDTH-1];
        diff    = partial - {1'b0, opnd_i};
        if (div_mode_i) begin
            if (diff[WIDTH]) begin
                acc_o = {partial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULDIV_UNSIGNED_EN enables MULTU/DIVU; otherwise every op is treated as signed.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = clog2(WIDTH + 1);

    muldiv_state_t      state_q;
    logic               div_q, neg_q, rem_neg_q, zero_q;
    logic               busy_q, done_q, div_zero_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod_d;
    logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
    logic [WIDTH-1:0]   abs_a, abs_b, quot_d, rem_d;
    logic               op_div, op_signed, a_neg, b_neg;

    always_comb begin
        op_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MULDIV_UNSIGNED_EN
        op_signed = (op == OP_MULT) || (op == OP_DIV);
`else
        op_signed = 1'b1;
`endif
        a_neg  = op_signed & a[WIDTH-1];
        b_neg  = op_signed & b[WIDTH-1];
        abs_a  = a_neg ? -a : a;
        abs_b  = b_neg ? -b : b;
        prod_d = neg_q ? -acc_q : acc_q;
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        quot_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_d  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode_i (div_q),
        .acc_i      (acc_q),
        .opnd_i     (opnd_q),
        .acc_o      (acc_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            div_q      <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            zero_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q    <= 1'b1;
                        div_q     <= op_div;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        cnt_q     <= CNT_W'(WIDTH);
                        if (op_div) begin
                            acc_q  <= {{WIDTH{1'b0}}, abs_a};
                            opnd_q <= abs_b;
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, abs_b};
                            opnd_q <= abs_a;
                        end
                        if (op_div && (b == '0)) begin
                            zero_q  <= 1'b1;
                            state_q <= FIX;
                        end else begin
                            zero_q  <= 1'b0;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= FIX;
                end
                FIX: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    if (zero_q) begin
                        div_zero_q <= 1'b1;
                    end else if (div_q) begin
                        hi_q <= rem_d;
                        lo_q <= quot_d;
                    end else begin
                        {hi_q, lo_q} <= prod_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32); expected results come from a
// behavioural arithmetic model and are compared when done pulses.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] ph, input logic [W-1:0] pl);
        exp_t        e;
        logic        sg;
        longint      sq, sr;
        logic [63:0] p;
`ifdef MULDIV_UNSIGNED_EN
        sg = !o[0];
`else
        sg = 1'b1;
`endif
        e.dz  = 1'b0;
        e.lat = W + 1;
        if (!o[1]) begin
            if (sg) p = 64'(longint'($signed(x)) * longint'($signed(y)));
            else    p = {32'b0, x} * {32'b0, y};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (y == '0) begin
            e.hi  = ph;
            e.lo  = pl;
            e.dz  = 1'b1;
            e.lat = 1;
        end else if (sg) begin
            sq   = longint'($signed(x)) / longint'($signed(y));
            sr   = longint'($signed(x)) % longint'($signed(y));
            e.lo = 32'(sq);
            e.hi = 32'(sr);
        end else begin
            e.lo = x / y;
            e.hi = x % y;
        end
        return e;
    endfunction

    // Issue one op; poke_at >= 0 fires a stray start that many cycles in.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int poke_at);
        exp_t e;
        int   n;
        e = model(o, x, y, model_hi, model_lo);
        sb.push_back(e);
        model_hi = e.hi;
        model_lo = e.lo;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        check_val("busy_after_start", 64'(busy), 64'(1));
        n = 0;
        while (!done && n < 100) begin
            start = (n == poke_at);
            if (start) op = OP_DIV;
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        check_val("latency", 64'(n), 64'(e.lat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("hi", 64'(hi), 64'(e.hi));
            check_val("lo", 64'(lo), 64'(e.lo));
            check_val("div_zero", 64'(div_zero), 64'(e.dz));
            check_val("busy_at_done", 64'(busy), 64'(0));
            $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d", o, x, y, hi, lo, div_zero, n);
        end
        @(negedge clk);
        check_val("done_one_cycle", 64'(done), 64'(0));
        check_val("hi_hold", 64'(hi), 64'(e.hi));
    endtask

    initial begin
        int ndone;
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_done", 64'(done), 64'(0));
        check_val("rst_dz", 64'(div_zero), 64'(0));
        check_val("rst_hi", 64'(hi), 64'(0));
        check_val("rst_lo", 64'(lo), 64'(0));

        run_op(OP_MULT,  32'hFFFFFFFD, 32'd7, -1);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, -1);
        run_op(OP_DIV,   32'hFFFFFFF9, 32'd2, -1);
        run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, -1);
        run_op(OP_DIVU,  32'd59, 32'd6, -1);
        run_op(OP_DIVU,  32'd100, 32'd0, -1);
        run_op(OP_DIV,   32'hFFFFFF00, 32'd0, -1);
        run_op(OP_MULT,  32'h12345678, 32'hFEDCBA98, 10);
        run_op(OP_DIVU,  32'hFFFFFFFF, 32'h00000003, -1);
        run_op(OP_MULTU, 32'h80000000, 32'h80000000, -1);
        for (int i = 0; i < 8; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(1, 9));
            run_op(ro, ra, rb, -1);
        end

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        op = OP_MULT; a = 32'd1234; b = 32'd5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("midrst_busy", 64'(busy), 64'(0));
        check_val("midrst_hi", 64'(hi), 64'(0));
        check_val("midrst_lo", 64'(lo), 64'(0));
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_val("no_done_after_reset", 64'(ndone), 64'(0));
        $display("mid-op reset: busy=%b hi=%h lo=%h dones=%0d", busy, hi, lo, ndone);
        run_op(OP_DIV, 32'd1000, 32'hFFFFFFF9, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
